irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
- Shares the CPU's single external interrupt line among NSRC sources: timer irq, UART, SD, and others.
- Latches source requests, masks them with a software enable register, and picks the winner by fixed priority (lowest index wins).
- Sequences service through a claim/complete handshake on the MMIO bus. Sits between the peripherals and the core's interrupt input.

Parameters:
- NSRC, 8, number of interrupt sources (1..31); source i has ID i+1, and ID 0 means none.
- EDGE_MASK, 8'h01, bit i = 1: source i is rising-edge triggered (timer pulse); bit i = 0: source i is level triggered.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- a  in  3  register select
- d  in  32  write data, byte-reversed bus order
- we  in  1  write strobe, one cycle
- rd  in  1  read strobe, one cycle; qualifies claim side effects
- spo  out  32  read data, combinational on a and state, byte-reversed bus order
- irq_src  in  NSRC  raw source requests, synchronous to clk
- irq_out  out  1  registered interrupt request to the CPU

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Bus byte order: register value v appears on spo as {v[7:0],v[15:8],v[23:16],v[31:24]}. Written values are un-reversed the same way.
- Register map:
  - a=0: pending, read-only.
  - a=1: enable, read/write, low NSRC bits.
  - a=2: claim (read) / complete (write).
  - a=3: status {30'b0, state[1:0]}.
  - a=4: claim_count, read-only.
  - Other addresses read 0; writes to them are ignored.
- Reset values: pending=0, enable=0, state=IDLE, in_service_id=0, claim_count=0, irq_out=0, edge-detect history=0.
- Edge sources: irq_src registered once (src_q). Pending bit sets when irq_src & ~src_q. It clears only on a claim of that source.
- Level sources: pending bit = irq_src, except while that source is in service, when it reads 0.
- Winner: lowest index i with pending[i] & enable[i]. win_id = i+1, or 0 if none.
- States and transitions:
  - IDLE: when win_id != 0, go to PEND.
  - PEND: when rd & a==2, go to SERVICE. When win_id drops to 0 (enable cleared, or level source released), go to IDLE.
  - SERVICE: when we & a==2 & data == in_service_id, go to IDLE. A mismatched ID is ignored and the state stays SERVICE.
- irq_out = (state==PEND), registered.
  - Rises 2 cycles after the source edge appears on irq_src: 1 cycle for pending, 1 for PEND.
  - Falls the cycle after the claim.
- Claim read (rd & a==2):
  - spo returns win_id in the same cycle.
  - In PEND: latches in_service_id=win_id, clears an edge source's pending bit, and increments claim_count (wraps at 2^32-1 to 0).
  - In IDLE or SERVICE: returns 0 with no side effects.
- A read of a==2 without rd returns win_id with no side effects.
- Simultaneous new edge and claim-clear on the same source: set wins, so the bit stays pending.
- Write to enable in the same cycle as a claim: the claim uses the old enable.
- Reset asserted mid-SERVICE: immediate return to the reset values. The next request still needs a fresh edge (src_q=0 after reset, so a level-high edge source re-triggers once).

Decomposition:
- Shared package pCPU.vh: register offsets (IRQ_PENDING=0, IRQ_ENABLE=1, IRQ_CLAIM=2, IRQ_STATUS=3, IRQ_COUNT=4), state encodings (IDLE=0, PEND=1, SERVICE=2), and the byte-swap macro.
- One natural sub-module: irq_prio_enc, a combinational lowest-index priority encoder from NSRC bits to ID.

Test Plan:
- Reset, enable=0x01, pulse irq_src[0] for 1 cycle -> irq_out high 2 cycles later; claim read returns 0x01000000 on the bus (ID 1); irq_out low next cycle; claim_count=1.
- Sources 0 and 3 pending together, enable=0x09 -> claim returns ID 1. Complete with 1 -> back to PEND; second claim returns ID 4.
- In SERVICE with ID 1, write complete with ID 2 -> status stays 2, irq_out stays 0. Write ID 1 -> status 0.
- Level source 3 held high, enabled, claimed -> pending[3] reads 0 while in service. After complete, still high -> irq_out reasserts. Drop before complete -> stays IDLE.
- Edge on source 0 in the exact cycle it is claimed -> pending[0]=1 afterwards; a second claim after complete returns 1.
- Assert rst mid-SERVICE -> irq_out=0, status=0, enable=0, claim_count=0 immediately (asynchronously). Claim read in IDLE returns 0.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: register offsets, FSM states,
// and the byte reversal used on the MMIO data bus.
package irq_arbiter_pkg;

  localparam int ID_W = 5;

  localparam logic [2:0] IRQ_PENDING = 3'd0;
  localparam logic [2:0] IRQ_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_CLAIM   = 3'd2;
  localparam logic [2:0] IRQ_STATUS  = 3'd3;
  localparam logic [2:0] IRQ_COUNT   = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Reversal is its own inverse, so it serves both the read and write paths.
  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// MMIO register bus between the CPU and the interrupt arbiter.
interface irq_arbiter_if;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;

  modport master (output a, d, we, rd, input spo);
  modport slave  (input a, d, we, rd, output spo);
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder: returns index+1 of the first set bit, 0 if none.
module irq_prio_enc
  import irq_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]    req,
  output logic [ID_W-1:0] id
);

  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Arbitrates NSRC interrupt sources onto one CPU interrupt line, with a
// claim/complete handshake through a small MMIO register file.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int              NSRC      = 8,
  parameter logic [NSRC-1:0] EDGE_MASK = {{(NSRC-1){1'b0}}, 1'b1}
) (
  input  logic            clk,
  input  logic            rst,
  irq_arbiter_if.slave    bus,
  input  logic [NSRC-1:0] irq_src,
  output logic            irq_out
);

  state_t            state, state_nxt;
  logic [NSRC-1:0]   src_q, pend_edge, enable;
  logic [NSRC-1:0]   pending, svc_mask, edge_clr, req;
  logic [ID_W-1:0]   in_service_id, win_id;
  logic [31:0]       claim_count, wdata, rdata;
  logic              claim_rd, claim_ok, complete_ok;

  assign wdata       = bswap32(bus.d);
  assign claim_rd    = bus.rd && (bus.a == IRQ_CLAIM);
  assign claim_ok    = claim_rd && (state == PEND) && (win_id != '0);
  assign complete_ok = bus.we && (bus.a == IRQ_CLAIM) && (state == SERVICE)
                       && (wdata == 32'(in_service_id));

  always_comb begin
    svc_mask = '0;
    edge_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      svc_mask[i] = (state == SERVICE) && (in_service_id == ID_W'(i + 1));
      edge_clr[i] = claim_ok && (win_id == ID_W'(i + 1));
    end
  end

  // Level sources follow the wire directly but hide while being serviced.
  assign pending = (pend_edge & EDGE_MASK) | (irq_src & ~EDGE_MASK & ~svc_mask);
  assign req     = pending & enable;

  irq_prio_enc #(.N(NSRC)) u_prio_enc (
    .req (req),
    .id  (win_id)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_id != '0) state_nxt = PEND;
      PEND: begin
        if (claim_ok)           state_nxt = SERVICE;
        else if (win_id == '0)  state_nxt = IDLE;
      end
      SERVICE: if (complete_ok) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      irq_out       <= 1'b0;
      src_q         <= '0;
      pend_edge     <= '0;
      enable        <= '0;
      in_service_id <= '0;
      claim_count   <= '0;
    end else begin
      state     <= state_nxt;
      irq_out   <= (state_nxt == PEND);
      src_q     <= irq_src;
      // A fresh edge overrides a clear from a claim in the same cycle.
      pend_edge <= ((pend_edge & ~edge_clr) | (irq_src & ~src_q)) & EDGE_MASK;
      if (bus.we && (bus.a == IRQ_ENABLE)) enable <= wdata[NSRC-1:0];
      if (claim_ok) begin
        in_service_id <= win_id;
        claim_count   <= claim_count + 32'd1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.a)
      IRQ_PENDING: rdata[NSRC-1:0] = pending;
      IRQ_ENABLE:  rdata[NSRC-1:0] = enable;
      IRQ_CLAIM:   if (!(claim_rd && (state != PEND))) rdata = 32'(win_id);
      IRQ_STATUS:  rdata[1:0] = state;
      IRQ_COUNT:   rdata = claim_count;
      default:     rdata = '0;
    endcase
  end

  assign bus.spo = bswap32(rdata);

endmodule

// File: tb/tb_irq_arbiter.sv
// Randomized and directed checks of irq_arbiter against a behavioural model.
module tb_irq_arbiter;

  localparam int         NSRC = 8;
  localparam logic [7:0] EDGE = 8'h01;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NSRC-1:0] src = '0;
  logic            irq_out;

  irq_arbiter_if bus ();

  irq_arbiter #(.NSRC(NSRC), .EDGE_MASK(EDGE)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .irq_src (src),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: plain variables describing what software should observe.
  bit          m_pe[NSRC];
  bit          m_sq[NSRC];
  bit          m_en[NSRC];
  int          m_state;
  int          m_isid;
  int unsigned m_count;
  bit          m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] bs(input logic [31:0] v);
    return {<<8{v}};
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_pe[i] = 0; m_sq[i] = 0; m_en[i] = 0;
    end
    m_state = 0; m_isid = 0; m_count = 0; m_irq = 0;
  endfunction

  function automatic bit m_pending(input int i);
    if (EDGE[i]) return m_pe[i];
    return src[i] && !(m_state == 2 && m_isid == i + 1);
  endfunction

  function automatic int m_win();
    for (int i = 0; i < NSRC; i++)
      if (m_pending(i) && m_en[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_read();
    logic [31:0] v = 0;
    case (bus.a)
      3'd0: for (int i = 0; i < NSRC; i++) v[i] = m_pending(i);
      3'd1: for (int i = 0; i < NSRC; i++) v[i] = m_en[i];
      3'd2: v = (bus.rd && m_state != 1) ? 0 : m_win();
      3'd3: v = m_state;
      3'd4: v = m_count;
      default: v = 0;
    endcase
    return bs(v);
  endfunction

  function automatic void m_update();
    int w = m_win();
    logic [31:0] wd = bs(bus.d);
    bit claim = bus.rd && bus.a == 3'd2 && m_state == 1 && w != 0;
    bit comp  = bus.we && bus.a == 3'd2 && m_state == 2 && wd == 32'(m_isid);
    int ns = m_state;
    if (m_state == 0 && w != 0) ns = 1;
    else if (m_state == 1 && claim) ns = 2;
    else if (m_state == 1 && w == 0) ns = 0;
    else if (m_state == 2 && comp) ns = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (EDGE[i]) begin
        if (claim && w == i + 1) m_pe[i] = 0;
        if (src[i] && !m_sq[i]) m_pe[i] = 1;
      end
      m_sq[i] = src[i];
    end
    if (bus.we && bus.a == 3'd1)
      for (int i = 0; i < NSRC; i++) m_en[i] = wd[i];
    if (claim) begin
      m_isid = w;
      m_count++;
    end
    m_state = ns;
    m_irq = (ns == 1);
  endfunction

  // One bus cycle; entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic [2:0] ca, input logic [31:0] cd, input logic cwe,
                       input logic crd, output logic [31:0] obs);
    bus.a = ca; bus.d = cd; bus.we = cwe; bus.rd = crd;
    #3;
    obs = bus.spo;
    check("spo", bus.spo, m_read());
    check("irq_out", {31'b0, irq_out}, {31'b0, m_irq});
    m_update();
    @(posedge clk);
    #1;
    bus.we = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic idle(input int n);
    logic [31:0] o;
    for (int k = 0; k < n; k++) cycle(3'd7, 32'd0, 1'b0, 1'b0, o);
  endtask

  initial begin
    logic [31:0] o;
    bus.a = 0; bus.d = 0; bus.we = 0; bus.rd = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_irq", {31'b0, irq_out}, 32'd0);
    rst = 1'b0;

    // Single edge source
    cycle(3'd1, bs(32'h01), 1'b1, 1'b0, o);
    src = 8'h01; idle(1); src = 8'h00;
    check("irq_wait1", {31'b0, irq_out}, 32'd0);
    idle(1);
    check("irq_rise", {31'b0, irq_out}, 32'd1);
    cycle(3'd2, 0, 1'b0, 1'b1, o);
    check("claim_id1", o, 32'h0100_0000);
    check("irq_fall", {31'b0, irq_out}, 32'd0);
    cycle(3'd4, 0, 1'b0, 1'b0, o);
    check("count1", o, 32'h0100_0000);
    cycle(3'd2, bs(32'd1), 1'b1, 1'b0, o);

    // Priority between edge source 0 and level source 3
    cycle(3'd1, bs(32'h09), 1'b1, 1'b0, o);
    src = 8'h09; idle(1); src = 8'h08; idle(2);
    cycle(3'd2, 0, 1'b0, 1'b1, o);
    check("prio_first", o, bs(32'd1));
    cycle(3'd2, bs(32'd1), 1'b1, 1'b0, o);
    idle(1);
    cycle(3'd2, 0, 1'b0, 1'b1, o);
    check("prio_second", o, bs(32'd4));
    cycle(3'd0, 0, 1'b0, 1'b0, o);
    check("level_masked", o, 32'd0);

    // Wrong-ID complete is ignored
    cycle(3'd2, bs(32'd2), 1'b1, 1'b0, o);
    cycle(3'd3, 0, 1'b0, 1'b0, o);
    check("bad_complete", o, bs(32'd2));
    check("bad_irq", {31'b0, irq_out}, 32'd0);
    cycle(3'd2, bs(32'd4), 1'b1, 1'b0, o);
    cycle(3'd3, 0, 1'b0, 1'b0, o);
    check("good_complete", o, 32'd0);
    idle(1);
    check("level_reassert", {31'b0, irq_out}, 32'd1);
    cycle(3'd2, 0, 1'b0, 1'b1, o);
    check("level_claim", o, bs(32'd4));
    src = 8'h00; idle(1);
    cycle(3'd2, bs(32'd4), 1'b1, 1'b0, o);
    idle(2);
    check("level_dropped", {31'b0, irq_out}, 32'd0);
    cycle(3'd3, 0, 1'b0, 1'b0, o);
    check("level_idle", o, 32'd0);

    // Edge arriving in the claim cycle survives the clear
    src = 8'h01; idle(1); src = 8'h00; idle(2);
    src = 8'h01;
    cycle(3'd2, 0, 1'b0, 1'b1, o);
    src = 8'h00;
    check("sim_claim", o, bs(32'd1));
    cycle(3'd0, 0, 1'b0, 1'b0, o);
    check("sim_pending", o, bs(32'd1));
    cycle(3'd2, bs(32'd1), 1'b1, 1'b0, o);
    idle(2);
    cycle(3'd2, 0, 1'b0, 1'b1, o);
    check("sim_reclaim", o, bs(32'd1));

    // Asynchronous reset while in service
    #1 rst = 1'b1;
    bus.a = 3'd3; #1 check("rst_status", bus.spo, 32'd0);
    bus.a = 3'd1; #1 check("rst_enable", bus.spo, 32'd0);
    bus.a = 3'd4; #1 check("rst_count", bus.spo, 32'd0);
    check("rst_irq", {31'b0, irq_out}, 32'd0);
    m_reset();
    @(posedge clk); #1 rst = 1'b0;
    cycle(3'd2, 0, 1'b0, 1'b1, o);
    check("idle_claim", o, 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic [2:0]  ra;
      logic [31:0] rdv;
      logic        rwe, rrd;
      if ($urandom_range(0, 3) == 0) src[0] = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) src[7:1] = 7'($urandom);
      ra  = 3'($urandom_range(0, 7));
      rwe = $urandom_range(0, 7) == 0;
      rrd = $urandom_range(0, 3) == 0;
      rdv = $urandom;
      if (ra == 3'd2 && $urandom_range(0, 1) == 1) rdv = bs(32'(m_isid));
      if (ra == 3'd1 && $urandom_range(0, 3) == 0) rdv = 32'd0;
      if (ra == 3'd1) rdv = rdv & 32'hFF00_0000;
      cycle(ra, rdv, rwe, rrd, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
